uart_tx_buffered: RTL

Buffered UART transmitter. Accepts bytes through a single-cycle strobe handshake, queues them in a small synchronous FIFO, and serializes each one onto TxD as a start bit, 8 data bits LSB-first, an optional parity bit and 1 or 2 stop bits. It is the transmit-side companion used wherever the design must send bytes faster than one per frame, e.g. echoing or reporting decoded data to a host terminal.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo.sv | 54 +++++
 rtl/uart_tx_buffered.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: frame constants, FSM states and
// the bit-period calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Bit period in clocks, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock FIFO with natural-wrap pointers; a push on a full FIFO is
// still accepted when a pop happens on the same edge.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_next, rd_next;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign wr_next  = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_next  = rd_ptr + {{AW{1'b0}}, do_pop};

  // Head is read combinationally so the consumer can pop and use it on one edge.
  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      full   <= (wr_next[AW] != rd_next[AW]) &&
                (wr_next[AW-1:0] == rd_next[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes queue in a FIFO and are framed as
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] datain_ext,
  input  logic       new_in,
  output logic       TxD,
  output logic       busy,
  output logic       full,
  output logic       error
);

  localparam int              DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(DIV - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic            ODD_BIT   = (PARITY_ODD != 0);

  tx_state_t            state_reg, state_next;
  logic [CW-1:0]        baud_reg, baud_next;
  logic [2:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 txd_reg, txd_next;
  logic                 error_reg;
  logic                 pop, fifo_empty, fifo_full, overflow;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 baud_tick;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (new_in),
    .pop      (pop),
    .din      (datain_ext),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign baud_tick = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    txd_next    = txd_reg;
    pop         = 1'b0;
    case (state_reg)
      IDLE: begin
        txd_next = 1'b1;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_next  = fifo_dout;
          parity_next = ^fifo_dout ^ ODD_BIT;
          txd_next    = 1'b0;
          baud_next   = '0;
          bit_next    = '0;
          state_next  = START;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_next  = '0;
          txd_next   = shift_reg[0];
          state_next = DATA;
        end else begin
          baud_next = baud_reg + CW'(1);
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_next = '0;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PARITY_EN != 0) begin
              txd_next   = parity_reg;
              state_next = PARITY;
            end else begin
              txd_next   = 1'b1;
              state_next = STOP;
            end
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = shift_reg >> 1;
            txd_next   = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + CW'(1);
        end
      end
      PARITY: begin
        if (baud_tick) begin
          baud_next  = '0;
          bit_next   = '0;
          txd_next   = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + CW'(1);
        end
      end
      STOP: begin
        if (baud_tick) begin
          baud_next = '0;
          if (bit_reg == STOP_LAST) begin
            bit_next = '0;
            // Queued byte starts immediately, no idle gap between frames.
            if (!fifo_empty) begin
              pop         = 1'b1;
              shift_next  = fifo_dout;
              parity_next = ^fifo_dout ^ ODD_BIT;
              txd_next    = 1'b0;
              state_next  = START;
            end else begin
              txd_next   = 1'b1;
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + CW'(1);
        end
      end
      default: begin
        txd_next   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      txd_reg    <= 1'b1;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      txd_reg    <= txd_next;
      if (overflow) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign TxD   = txd_reg;
  assign busy  = (state_reg != IDLE) || !fifo_empty;
  assign full  = fifo_full;
  assign error = error_reg;

endmodule
